op_sequencer: RTL and testbench
===============================

Name: op_sequencer

Overview:
- Registered controller that sequences a 4-phase multi-cycle datapath operation: IDLE -> LOAD -> EXEC -> FINISH -> IDLE.
- Phase encoding is the team's standard 2-bit sequence: 00, 01, 10, 11.
- Drives one-hot phase strobes (load/exec/store) into the datapath.
- Latches the operation mode at start, supports a stall input, and counts completed operations.

Parameters:
- EXEC_CYCLES, 4, number of cycles spent in EXEC; legal range 1..(2^CNT_W).
- CNT_W, 3, width of the EXEC cycle counter.
- OPS_W, 8, width of the completed-operation counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin an operation; sampled only in IDLE.
- mode  input  1  operation select; captured into op_mode on an accepted start.
- stall  input  1  freezes phase and counters while high, in LOAD and EXEC only.
- state  output  2  current phase: 00 IDLE, 01 LOAD, 10 EXEC, 11 FINISH.
- load_en  output  1  high exactly when state==LOAD and stall==0.
- exec_en  output  1  high exactly when state==EXEC and stall==0.
- store_en  output  1  high exactly when state==FINISH.
- op_mode  output  1  registered mode of the operation in progress.
- busy  output  1  high whenever state!=IDLE.
- done  output  1  one-cycle pulse, registered, asserted the cycle after FINISH.
- exec_cnt  output  CNT_W  EXEC cycles completed in the current operation.
- op_count  output  OPS_W  completed operations since reset; wraps modulo 2^OPS_W.

Behaviour:
- Reset values (rst high at a clock edge, in any state):
  - state=00, op_mode=0, exec_cnt=0, op_count=0, done=0.
  - Combinational strobes follow state, so they read 0.
  - An operation in progress is abandoned, with no done and no op_count increment.
- IDLE:
  - start=1 -> LOAD next cycle; op_mode<=mode; exec_cnt<=0.
  - start=0 -> remain in IDLE.
  - start is ignored in every other state (no queuing).
- LOAD:
  - stall=0 -> EXEC next cycle.
  - stall=1 -> remain in LOAD with load_en=0.
  - Minimum LOAD duration is 1 cycle.
- EXEC:
  - Each cycle with stall=0: exec_cnt increments.
  - When exec_cnt==EXEC_CYCLES-1 with stall=0, go to FINISH next cycle; exec_cnt then reads EXEC_CYCLES, saturated.
  - stall=1 holds both state and exec_cnt; exec_en=0.
  - Unstalled EXEC occupancy is exactly EXEC_CYCLES cycles.
- FINISH:
  - Lasts exactly 1 cycle and ignores stall; store_en=1.
  - Next cycle: state=IDLE, done=1, op_count+=1 (wrapping at 2^OPS_W).
- done:
  - High for exactly one cycle, coincident with the first IDLE cycle after FINISH.
  - A start in that same cycle is accepted normally, giving back-to-back operations.
- Latency, unstalled, start accepted at edge T:
  - LOAD at T+1.
  - EXEC at T+2 .. T+1+EXEC_CYCLES.
  - FINISH at T+2+EXEC_CYCLES.
  - done at T+3+EXEC_CYCLES.
  - Total of 3+EXEC_CYCLES cycles start-to-done.
- Fixed properties:
  - op_mode is stable from LOAD through FINISH; a mode change mid-operation has no effect.
  - The unreachable/illegal state encoding cannot occur; the default branch returns to IDLE.
  - Strobes are mutually exclusive at all times.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, start=0 -> state=00, busy=0, strobes=0, op_count=0, done never asserted over 10 cycles.
- Basic op, EXEC_CYCLES=4:
  - Stimulus: start=1 with mode=1 for one cycle at T.
  - Expect state 01 at T+1, 10 at T+2..T+5, 11 at T+6, 00 at T+7.
  - Expect exec_en high for 4 cycles, store_en high at T+6, done at T+7, op_mode=1, op_count=1.
- Stall: assert stall for 2 cycles in LOAD and 3 cycles in mid-EXEC.
  - Expect done delayed by exactly 5 cycles vs the unstalled case.
  - Expect exec_cnt frozen and exec_en=0 during the stall.
  - Expect exec_en total still 4 cycles.
- Ignored inputs: toggle start and mode every cycle while busy -> single operation completes, op_mode equals the value at acceptance, op_count increments by 1 only.
- Back-to-back: hold start=1 continuously for 3 operations -> done pulses spaced 7 cycles apart (EXEC_CYCLES=4), op_count=3.
- Reset mid-EXEC and wrap:
  - Stimulus: rst=1 during the second EXEC cycle.
  - Expect state=00, exec_cnt=0, no done pulse, op_count unchanged at 0.
  - Separately, run 256 operations with OPS_W=8 -> op_count wraps to 0.

Source files
------------

// File: rtl/op_sequencer.sv
// Four-phase operation sequencer: IDLE -> LOAD -> EXEC -> FINISH -> IDLE.
// It drives one-hot phase strobes, latches the operation mode and counts completed operations.
module op_sequencer #(
    parameter int EXEC_CYCLES = 4,
    parameter int CNT_W       = 3,
    parameter int OPS_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic             stall,
    output logic [1:0]       state,
    output logic             load_en,
    output logic             exec_en,
    output logic             store_en,
    output logic             op_mode,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] exec_cnt,
    output logic [OPS_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LOAD   = 2'b01,
        EXEC   = 2'b10,
        FINISH = 2'b11
    } phase_t;

    // The compare is one bit wider so that EXEC_CYCLES == 2**CNT_W is legal.
    localparam logic [CNT_W:0]   EXEC_LAST = (CNT_W+1)'(EXEC_CYCLES - 1);
    localparam logic [CNT_W-1:0] EXEC_SAT  = (EXEC_CYCLES >= (1 << CNT_W)) ?
                                             {CNT_W{1'b1}} : CNT_W'(EXEC_CYCLES);

    phase_t cur_phase;
    phase_t nxt_phase;
    logic   exec_last;

    assign exec_last = ({1'b0, exec_cnt} == EXEC_LAST);
    assign state     = cur_phase;
    assign busy      = (cur_phase != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_phase <= IDLE;
        end else begin
            cur_phase <= nxt_phase;
        end
    end

    always_comb begin
        nxt_phase = cur_phase;
        load_en   = 1'b0;
        exec_en   = 1'b0;
        store_en  = 1'b0;
        case (cur_phase)
            IDLE: begin
                if (start) begin
                    nxt_phase = LOAD;
                end
            end
            LOAD: begin
                if (!stall) begin
                    load_en   = 1'b1;
                    nxt_phase = EXEC;
                end
            end
            EXEC: begin
                if (!stall) begin
                    exec_en = 1'b1;
                    if (exec_last) begin
                        nxt_phase = FINISH;
                    end
                end
            end
            FINISH: begin
                store_en  = 1'b1;
                nxt_phase = IDLE;
            end
            default: nxt_phase = IDLE;
        endcase
    end

    // exec_cnt and op_count advance on the very strobes the datapath sees.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_mode  <= 1'b0;
            exec_cnt <= '0;
            op_count <= '0;
            done     <= 1'b0;
        end else begin
            done <= store_en;
            if (cur_phase == IDLE && start) begin
                op_mode  <= mode;
                exec_cnt <= '0;
            end
            if (exec_en) begin
                exec_cnt <= exec_last ? EXEC_SAT : exec_cnt + 1'b1;
            end
            if (store_en) begin
                op_count <= op_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_op_sequencer.sv
// Bench for op_sequencer: directed latency, stall, reset and wrap scenarios plus random stimulus,
// all checked every cycle against an operation-level reference model.
module tb_op_sequencer;

    localparam int EXEC_CYCLES = 4;
    localparam int CNT_W       = 3;
    localparam int OPS_W       = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             mode = 1'b0;
    logic             stall = 1'b0;
    logic [1:0]       state;
    logic             load_en;
    logic             exec_en;
    logic             store_en;
    logic             op_mode;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] exec_cnt;
    logic [OPS_W-1:0] op_count;

    always #5 clk = ~clk;

    op_sequencer #(
        .EXEC_CYCLES(EXEC_CYCLES),
        .CNT_W      (CNT_W),
        .OPS_W      (OPS_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .mode    (mode),
        .stall   (stall),
        .state   (state),
        .load_en (load_en),
        .exec_en (exec_en),
        .store_en(store_en),
        .op_mode (op_mode),
        .busy    (busy),
        .done    (done),
        .exec_cnt(exec_cnt),
        .op_count(op_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: where the current operation is (0 idle, 1 loading, 2 executing, 3 storing),
    // how many execute cycles it has had, how many operations have completed.
    int   m_ph    = 0;
    int   m_execs = 0;
    int   m_ops   = 0;
    bit   m_mode  = 1'b0;
    bit   m_done  = 1'b0;
    bit   m_valid = 1'b0;
    logic obs_done;
    logic obs_exec;

    task automatic model_edge();
        if (rst) begin
            m_ph = 0; m_execs = 0; m_mode = 1'b0; m_ops = 0; m_done = 1'b0; m_valid = 1'b1;
        end else begin
            m_done = (m_ph == 3);
            case (m_ph)
                0: if (start) begin m_ph = 1; m_mode = mode; m_execs = 0; end
                1: if (!stall) m_ph = 2;
                2: if (!stall) begin
                       m_execs = m_execs + 1;
                       if (m_execs == EXEC_CYCLES) m_ph = 3;
                   end
                default: begin m_ph = 0; m_ops = (m_ops + 1) % (1 << OPS_W); end
            endcase
        end
    endtask

    // One clock: apply inputs, check all outputs against the model, then take the edge.
    task automatic step(input logic r, input logic s, input logic md, input logic st);
        rst = r; start = s; mode = md; stall = st;
        #1;
        obs_done = done;
        obs_exec = exec_en;
        if (m_valid) begin
            chk("state",    int'(state),    m_ph);
            chk("busy",     int'(busy),     int'(m_ph != 0));
            chk("load_en",  int'(load_en),  int'(m_ph == 1 && !st));
            chk("exec_en",  int'(exec_en),  int'(m_ph == 2 && !st));
            chk("store_en", int'(store_en), int'(m_ph == 3));
            chk("done",     int'(done),     int'(m_done));
            chk("op_mode",  int'(op_mode),  int'(m_mode));
            chk("exec_cnt", int'(exec_cnt), m_execs);
            chk("op_count", int'(op_count), m_ops);
            chk("onehot",   int'(load_en) + int'(exec_en) + int'(store_en) <= 1 ? 1 : 0, 1);
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // One operation; ls stall cycles in LOAD, es stall cycles after two EXEC cycles.
    task automatic do_op(input bit m, input int ls, input int es, input bit tog,
                         output int lat, output int ne);
        logic st, s, md;
        lat = -1;
        ne  = 0;
        step(1'b0, 1'b1, m, 1'b0);
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            st = (k < 1 + ls) || (k >= 4 + ls && k < 4 + ls + es);
            s  = (tog && m_ph != 0) ? ((k % 2) == 1) : 1'b0;
            md = tog ? ((k % 2) == 0) : m;
            step(1'b0, s, md, st);
            if (obs_exec) ne++;
            if (obs_done) lat = k;
        end
        if (lat < 0) chk("op_timeout", 0, 1);
    endtask

    int exp_ops;
    int lat;
    int ne;
    int nd;
    int dcyc[3];

    initial begin
        @(posedge clk);
        #1;

        // Reset, then idle
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_state", int'(state), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ops", int'(op_count), 0);
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            if (obs_done) nd++;
        end
        chk("idle_done", nd, 0);
        exp_ops = 0;

        // Reset during the second EXEC cycle abandons the operation
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("midrst_state", int'(state), 0);
        chk("midrst_cnt", int'(exec_cnt), 0);
        chk("midrst_ops", int'(op_count), 0);
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            if (obs_done) nd++;
        end
        chk("midrst_done", nd, 0);

        // Basic operation, mode 1
        do_op(1'b1, 0, 0, 1'b0, lat, ne);
        exp_ops++;
        chk("basic_lat", lat, 3 + EXEC_CYCLES);
        chk("basic_execs", ne, EXEC_CYCLES);
        chk("basic_mode", int'(op_mode), 1);
        chk("basic_ops", int'(op_count), exp_ops);

        // Stalls in LOAD and mid-EXEC
        do_op(1'b0, 2, 3, 1'b0, lat, ne);
        exp_ops++;
        chk("stall_lat", lat, 3 + EXEC_CYCLES + 5);
        chk("stall_execs", ne, EXEC_CYCLES);
        chk("stall_ops", int'(op_count), exp_ops);

        // start and mode toggling while busy are ignored
        do_op(1'b1, 0, 0, 1'b1, lat, ne);
        exp_ops++;
        chk("tog_lat", lat, 3 + EXEC_CYCLES);
        chk("tog_mode", int'(op_mode), 1);
        chk("tog_ops", int'(op_count), exp_ops);
        do_op(1'b0, 0, 0, 1'b1, lat, ne);
        exp_ops++;
        chk("tog_mode0", int'(op_mode), 0);
        chk("tog_ops0", int'(op_count), exp_ops);

        // Back-to-back operations with start held high
        nd = 0;
        for (int k = 0; k < 40 && nd < 3; k++) begin
            step(1'b0, (k <= 2 * (3 + EXEC_CYCLES)), 1'b1, 1'b0);
            if (obs_done) begin
                dcyc[nd] = k;
                nd++;
            end
        end
        chk("b2b_count", nd, 3);
        if (nd == 3) begin
            chk("b2b_first", dcyc[0], 3 + EXEC_CYCLES);
            chk("b2b_gap1", dcyc[1] - dcyc[0], 3 + EXEC_CYCLES);
            chk("b2b_gap2", dcyc[2] - dcyc[1], 3 + EXEC_CYCLES);
        end
        exp_ops += 3;
        chk("b2b_ops", int'(op_count), exp_ops);

        // Random stimulus, occasional reset
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 64) == 0, $urandom % 2, $urandom % 2, ($urandom % 4) == 0);
        end

        // 2**OPS_W operations wrap op_count back to zero
        step(1'b1, 1'b0, 1'b0, 1'b0);
        nd = 0;
        for (int k = 0; k < (1 << OPS_W) * (3 + EXEC_CYCLES) + 20 && nd < (1 << OPS_W); k++) begin
            step(1'b0, (k <= ((1 << OPS_W) - 1) * (3 + EXEC_CYCLES)), $urandom % 2, 1'b0);
            if (obs_done) nd++;
        end
        chk("wrap_dones", nd, 1 << OPS_W);
        chk("wrap_count", int'(op_count), 0);
        chk("wrap_idle", int'(state), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
